// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter that owns one shared bank of gated D latches. It sequences
// the bank's D and enable so that data is stable before, during and after the enable pulse.
module latch_bank_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int EN_CYCLES = 1
) (
   input  logic                     Clk,
   input  logic                     Resetn,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic                     done,
   output logic                     busy,
   output logic [WIDTH-1:0]         latch_D,
   output logic                     latch_Clk
);

   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, DONE} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    win_q, win_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic                lclk_q, lclk_d;

   logic                arb_found;
   logic [PTR_W-1:0]    arb_idx;
   logic [PTR_W:0]      arb_sum;
   logic [WIDTH-1:0]    arb_data;
   logic [N_REQ-1:0]    arb_onehot;

   // Search ptr, ptr+1, ... (mod N_REQ) for the first active request.
   always_comb begin
      arb_found  = 1'b0;
      arb_idx    = '0;
      arb_sum    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         arb_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (arb_sum >= (PTR_W+1)'(N_REQ)) begin
            arb_sum = arb_sum - (PTR_W+1)'(N_REQ);
         end
         if (!arb_found && req[arb_sum[PTR_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = arb_sum[PTR_W-1:0];
         end
      end
      arb_data   = '0;
      arb_onehot = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (arb_idx == PTR_W'(j)) begin
            arb_data      = wdata[j*WIDTH +: WIDTH];
            arb_onehot[j] = 1'b1;
         end
      end
   end

   // lclk_d defaults low so the enable can only be high while in ENABLE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      data_d  = data_q;
      lclk_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d = SETUP;
               win_d   = arb_idx;
               gnt_d   = arb_onehot;
               data_d  = arb_data;
            end
         end
         SETUP: begin
            state_d = ENABLE;
            cnt_d   = 4'(EN_CYCLES - 1);
            lclk_d  = 1'b1;
         end
         ENABLE: begin
            if (cnt_q == 4'd0) begin
               state_d = HOLD;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               lclk_d = 1'b1;
            end
         end
         HOLD: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         data_q  <= '0;
         lclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         data_q  <= data_d;
         lclk_q  <= lclk_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign latch_D   = data_q;
   assign latch_Clk = lclk_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: a default instance (EN_CYCLES=1) and a
// second instance with EN_CYCLES=3, each feeding a behavioural latch bank model.
module tb_latch_bank_arbiter;

   logic         Clk;
   logic         Resetn;
   logic [3:0]   req;
   logic [31:0]  wdata;
   logic [3:0]   gnt;
   logic         done;
   logic         busy;
   logic [7:0]   latch_D;
   logic         latch_Clk;

   logic [3:0]   req3;
   logic [31:0]  wdata3;
   logic [3:0]   gnt3;
   logic         done3;
   logic         busy3;
   logic [7:0]   latch_D3;
   logic         latch_Clk3;

   logic [7:0]   bankQ;
   logic [7:0]   bankQ3;
   int           dViolations;
   int           errorCount;
   int           checkCount;

   latch_bank_arbiter #(.N_REQ(4), .WIDTH(8), .EN_CYCLES(1)) dut (
      .Clk       (Clk),
      .Resetn    (Resetn),
      .req       (req),
      .wdata     (wdata),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .latch_D   (latch_D),
      .latch_Clk (latch_Clk)
   );

   latch_bank_arbiter #(.N_REQ(4), .WIDTH(8), .EN_CYCLES(3)) dut3 (
      .Clk       (Clk),
      .Resetn    (Resetn),
      .req       (req3),
      .wdata     (wdata3),
      .gnt       (gnt3),
      .done      (done3),
      .busy      (busy3),
      .latch_D   (latch_D3),
      .latch_Clk (latch_Clk3)
   );

   // Free-running 10-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Level-sensitive latch bank models; a reset abort leaves them untouched.
   always @(latch_Clk or latch_D or Resetn) begin
      if (latch_Clk && Resetn) bankQ = latch_D;
   end

   always @(latch_Clk3 or latch_D3 or Resetn) begin
      if (latch_Clk3 && Resetn) bankQ3 = latch_D3;
   end

   // Any movement of D while the enable is high is a setup/hold violation.
   always @(latch_D or latch_D3) begin
      if ((latch_Clk || latch_Clk3) && Resetn) dViolations++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] reqVal, input logic [31:0] wdataVal);
      req   = reqVal;
      wdata = wdataVal;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic waitGrant(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (gnt != 4'b0000) seen = 1'b1;
      end
      checkOutput({tag, "_grantSeen"}, 32'(seen), 32'd1);
   endtask

   // Walks one transaction cycle by cycle, optionally changing inputs during SETUP.
   task automatic runTxn(input string tag, input logic [3:0] expGnt, input logic [7:0] expData,
                         input bit modify, input logic [3:0] newReq, input logic [31:0] newWdata);
      waitGrant(tag);
      checkOutput({tag, "_gnt"},      32'(gnt),       32'(expGnt));
      checkOutput({tag, "_latchD"},   32'(latch_D),   32'(expData));
      checkOutput({tag, "_setupClk"}, 32'(latch_Clk), 32'd0);
      checkOutput({tag, "_busy"},     32'(busy),      32'd1);
      if (modify) applyStimulus(newReq, newWdata);
      tick();
      checkOutput({tag, "_enableClk"}, 32'(latch_Clk), 32'd1);
      checkOutput({tag, "_enableD"},   32'(latch_D),   32'(expData));
      tick();
      checkOutput({tag, "_holdClk"},  32'(latch_Clk), 32'd0);
      checkOutput({tag, "_holdDone"}, 32'(done),      32'd0);
      tick();
      checkOutput({tag, "_done"},     32'(done),  32'd1);
      checkOutput({tag, "_doneGnt"},  32'(gnt),   32'(expGnt));
      checkOutput({tag, "_bankQ"},    32'(bankQ), 32'(expData));
      tick();
      checkOutput({tag, "_doneLow"},  32'(done),    32'd0);
      checkOutput({tag, "_idleBusy"}, 32'(busy),    32'd0);
      checkOutput({tag, "_idleGnt"},  32'(gnt),     32'd0);
      checkOutput({tag, "_keepD"},    32'(latch_D), 32'(expData));
   endtask

   logic [6:0] expClk3;
   logic [6:0] expDone3;

   initial begin
      errorCount  = 0;
      checkCount  = 0;
      dViolations = 0;
      bankQ       = 8'h00;
      bankQ3      = 8'h00;
      req3        = 4'b0000;
      wdata3      = 32'h0;
      Resetn      = 1'b0;
      applyStimulus(4'b1111, 32'h44332211);

      // Reset holds everything quiet even with all requests pending.
      #2;
      checkOutput("rst_gnt",      32'(gnt),       32'd0);
      checkOutput("rst_done",     32'(done),      32'd0);
      checkOutput("rst_busy",     32'(busy),      32'd0);
      checkOutput("rst_latchD",   32'(latch_D),   32'h00);
      checkOutput("rst_latchClk", 32'(latch_Clk), 32'd0);
      tick();
      tick();
      checkOutput("rstEdge_gnt",  32'(gnt),  32'd0);
      checkOutput("rstEdge_busy", 32'(busy), 32'd0);
      #3 Resetn = 1'b1;

      // Round robin with every request held: 0,1,2,3,0.
      runTxn("rr0", 4'b0001, 8'h11, 1'b0, 4'b0, 32'h0);
      runTxn("rr1", 4'b0010, 8'h22, 1'b0, 4'b0, 32'h0);
      runTxn("rr2", 4'b0100, 8'h33, 1'b0, 4'b0, 32'h0);
      runTxn("rr3", 4'b1000, 8'h44, 1'b0, 4'b0, 32'h0);
      runTxn("rr4", 4'b0001, 8'h11, 1'b0, 4'b0, 32'h0);

      // Data capture: changing wdata and dropping req in SETUP has no effect.
      applyStimulus(4'b0010, 32'h44333C11);
      runTxn("cap", 4'b0010, 8'h3C, 1'b1, 4'b0000, 32'h4433FF11);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("cap_noRegrant", 32'({gnt, done}), 32'd0);
      end

      // Single write from requester 2 (ptr now points at 2).
      applyStimulus(4'b0100, 32'h44A5FF11);
      runTxn("single", 4'b0100, 8'hA5, 1'b1, 4'b0000, 32'h44A5FF11);

      // Reset during ENABLE: enable drops at once and no done follows.
      applyStimulus(4'b0100, 32'h445AFF11);
      waitGrant("abort");
      checkOutput("abort_gnt", 32'(gnt), 32'b0100);
      tick();
      checkOutput("abort_enable", 32'(latch_Clk), 32'd1);
      #2 Resetn = 1'b0;
      #1;
      checkOutput("abort_clk",  32'(latch_Clk), 32'd0);
      checkOutput("abort_gnt0", 32'(gnt),       32'd0);
      checkOutput("abort_busy", 32'(busy),      32'd0);
      checkOutput("abort_done", 32'(done),      32'd0);
      checkOutput("abort_D",    32'(latch_D),   32'h00);
      applyStimulus(4'b0110, 32'h445AFF11);
      tick();
      checkOutput("abortHold_done", 32'({gnt, done}), 32'd0);
      #3 Resetn = 1'b1;

      // ptr restarts at 0, so requester 1 beats requester 2.
      runTxn("postRst", 4'b0010, 8'hFF, 1'b1, 4'b0000, 32'h445AFF11);
      applyStimulus(4'b0010, 32'h445A7711);
      runTxn("postRst2", 4'b0010, 8'h77, 1'b1, 4'b0000, 32'h445A7711);

      // EN_CYCLES=3 instance: exact enable width and done timing.
      expClk3  = 7'b0001110;
      expDone3 = 7'b0100000;
      req3     = 4'b0001;
      wdata3   = 32'h000000C3;
      begin
         bit seen3;
         int highCount;
         seen3     = 1'b0;
         highCount = 0;
         for (int i = 0; i < 8 && !seen3; i++) begin
            tick();
            if (gnt3 != 4'b0000) seen3 = 1'b1;
         end
         checkOutput("en3_grantSeen", 32'(seen3), 32'd1);
         checkOutput("en3_gnt", 32'(gnt3), 32'b0001);
         req3 = 4'b0000;
         for (int t = 0; t < 7; t++) begin
            checkOutput($sformatf("en3_clk_t%0d", t),  32'(latch_Clk3), 32'(expClk3[t]));
            checkOutput($sformatf("en3_done_t%0d", t), 32'(done3),      32'(expDone3[t]));
            if (latch_Clk3) highCount++;
            if (t < 6) tick();
         end
         checkOutput("en3_highCount", 32'(highCount), 32'd3);
         checkOutput("en3_busyEnd",   32'(busy3),     32'd0);
         checkOutput("en3_bankQ",     32'(bankQ3),    32'hC3);
      end

      checkOutput("noDChangeWhileEnabled", 32'(dViolations), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
